// File: rtl/fixed_dwn_argmax.sv
// Sequential argmax over the per-class popcounts from the DWN group-sum stage.
// Scans one lane per cycle; ties keep the lowest index, matching software argmax.
module fixed_dwn_argmax #(
  parameter int NUM_GROUPS  = 10,
  parameter int COUNT_WIDTH = 4,
  parameter int IDX_WIDTH   = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [COUNT_WIDTH-1:0] data_in_0 [0:NUM_GROUPS-1],
  input  logic                   data_in_0_valid,
  output logic                   data_in_0_ready,
  output logic [IDX_WIDTH-1:0]   data_out_0,
  output logic [COUNT_WIDTH-1:0] data_out_0_max,
  output logic                   data_out_0_valid,
  input  logic                   data_out_0_ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [IDX_WIDTH-1:0] LAST_IDX  = IDX_WIDTH'(NUM_GROUPS - 1);
  localparam logic [IDX_WIDTH-1:0] FIRST_PTR = (NUM_GROUPS > 1) ? IDX_WIDTH'(1) : IDX_WIDTH'(0);

  state_t                 state_reg;
  state_t                 state_next;
  logic [COUNT_WIDTH-1:0] lane_reg [0:NUM_GROUPS-1];
  logic [IDX_WIDTH-1:0]   ptr_reg;
  logic [IDX_WIDTH-1:0]   best_idx_reg;
  logic [COUNT_WIDTH-1:0] best_val_reg;
  logic [IDX_WIDTH-1:0]   out_idx_reg;
  logic [COUNT_WIDTH-1:0] out_max_reg;

  logic                   load;
  logic                   last;
  logic                   better;
  logic [NUM_GROUPS-1:0]  lane_sel;
  logic [COUNT_WIDTH-1:0] cur_val;

  assign load = (state_reg == IDLE) && data_in_0_valid;
  assign last = (ptr_reg == LAST_IDX);

  // One-hot lane select keeps the mux free of out-of-range indexing.
  for (genvar gi = 0; gi < NUM_GROUPS; gi++) begin : g_sel
    assign lane_sel[gi] = (ptr_reg == IDX_WIDTH'(gi));
  end

  always_comb begin
    cur_val = '0;
    for (int i = 0; i < NUM_GROUPS; i++) begin
      if (lane_sel[i]) cur_val = lane_reg[i];
    end
  end

  // Strict compare: an equal count never displaces an earlier index.
  assign better = (cur_val > best_val_reg);

  always_ff @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < NUM_GROUPS; i++) lane_reg[i] <= data_in_0[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next       = state_reg;
    data_in_0_ready  = 1'b0;
    data_out_0_valid = 1'b0;
    case (state_reg)
      IDLE: begin
        data_in_0_ready = 1'b1;
        if (data_in_0_valid) state_next = (NUM_GROUPS == 1) ? DONE : SCAN;
      end
      SCAN: begin
        if (last) state_next = DONE;
      end
      DONE: begin
        data_out_0_valid = 1'b1;
        if (data_out_0_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Result registers only change when a scan completes, so they stay stable in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg      <= '0;
      best_idx_reg <= '0;
      best_val_reg <= '0;
      out_idx_reg  <= '0;
      out_max_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (data_in_0_valid) begin
            best_val_reg <= data_in_0[0];
            best_idx_reg <= '0;
            ptr_reg      <= FIRST_PTR;
            if (NUM_GROUPS == 1) begin
              out_idx_reg <= '0;
              out_max_reg <= data_in_0[0];
            end
          end
        end
        SCAN: begin
          if (better) begin
            best_val_reg <= cur_val;
            best_idx_reg <= ptr_reg;
          end
          if (last) begin
            out_idx_reg <= better ? ptr_reg : best_idx_reg;
            out_max_reg <= better ? cur_val : best_val_reg;
          end else begin
            ptr_reg <= ptr_reg + IDX_WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign data_out_0     = out_idx_reg;
  assign data_out_0_max = out_max_reg;

endmodule

// File: tb/tb_fixed_dwn_argmax.sv
// Self-checking bench for fixed_dwn_argmax: 4-lane build plus a 1-lane build,
// with expected results queued at input handshake and compared at output.
module tb_fixed_dwn_argmax;

  localparam int NG = 4;
  localparam int CW = 3;
  localparam int IW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [CW-1:0] din [0:NG-1];
  logic          din_valid, din_ready;
  logic [IW-1:0] dout;
  logic [CW-1:0] dout_max;
  logic          dout_valid, dout_ready;

  logic [CW-1:0] din1 [0:0];
  logic          din1_valid, din1_ready;
  logic [0:0]    dout1;
  logic [CW-1:0] dout1_max;
  logic          dout1_valid, dout1_ready;

  fixed_dwn_argmax #(.NUM_GROUPS(NG), .COUNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .data_in_0(din), .data_in_0_valid(din_valid), .data_in_0_ready(din_ready),
    .data_out_0(dout), .data_out_0_max(dout_max),
    .data_out_0_valid(dout_valid), .data_out_0_ready(dout_ready)
  );

  fixed_dwn_argmax #(.NUM_GROUPS(1), .COUNT_WIDTH(CW)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .data_in_0(din1), .data_in_0_valid(din1_valid), .data_in_0_ready(din1_ready),
    .data_out_0(dout1), .data_out_0_max(dout1_max),
    .data_out_0_valid(dout1_valid), .data_out_0_ready(dout1_ready)
  );

  int asserts  = 0;
  int failures = 0;

  typedef struct {
    int idx;
    int mx;
  } exp_t;

  exp_t sb[$];

  function automatic exp_t model(input int a, input int b, input int c, input int d);
    int   v[4];
    exp_t r;
    v = '{a, b, c, d};
    r.idx = 0;
    r.mx  = v[0];
    for (int i = 1; i < 4; i++) begin
      if (v[i] > r.mx) begin
        r.idx = i;
        r.mx  = v[i];
      end
    end
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_din(input int a, input int b, input int c, input int d);
    din[0] = CW'(a);
    din[1] = CW'(b);
    din[2] = CW'(c);
    din[3] = CW'(d);
  endtask

  // Presents a vector, waits for ready, queues the expected result, and
  // returns one edge after the loading edge with valid dropped.
  task automatic send(input int a, input int b, input int c, input int d);
    int n;
    n = 0;
    set_din(a, b, c, d);
    din_valid = 1'b1;
    while (!din_ready && n < 50) begin
      step();
      n++;
    end
    asserts++;
    if (din_ready !== 1'b1) begin
      failures++;
      $display("FAIL send_ready: in_ready=%b required 1", din_ready);
    end
    sb.push_back(model(a, b, c, d));
    step();
    din_valid = 1'b0;
  endtask

  // Called one edge after the loading edge with out_ready high.
  task automatic wait_result(input int exp_lat);
    int   lat;
    exp_t e;
    lat = 1;
    while (!dout_valid && lat < 40) begin
      step();
      lat++;
    end
    asserts++;
    if (dout_valid !== 1'b1) begin
      failures++;
      $display("FAIL result_timeout: out_valid=%b required 1", dout_valid);
    end
    asserts++;
    if (lat != exp_lat) begin
      failures++;
      $display("FAIL latency: got %0d cycles required %0d", lat, exp_lat);
    end
    asserts++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL scoreboard_empty: size=0 required >0");
    end else begin
      e = sb.pop_front();
      asserts++;
      if (dout !== IW'(e.idx)) begin
        failures++;
        $display("FAIL result_idx: got %0d required %0d", dout, e.idx);
      end
      asserts++;
      if (dout_max !== CW'(e.mx)) begin
        failures++;
        $display("FAIL result_max: got %0d required %0d", dout_max, e.mx);
      end
      $display("txn: idx=%0d max=%0d (expected %0d/%0d) latency=%0d", dout, dout_max, e.idx, e.mx, lat);
    end
    step();
    asserts++;
    if (dout_valid !== 1'b0 || din_ready !== 1'b1) begin
      failures++;
      $display("FAIL consume: out_valid=%b in_ready=%b required 0/1", dout_valid, din_ready);
    end
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    din_valid   = 1'b0;
    dout_ready  = 1'b1;
    din1_valid  = 1'b0;
    dout1_ready = 1'b1;
    set_din(0, 0, 0, 0);
    din1[0] = '0;
    #3;
    asserts++;
    if (dout_valid !== 1'b0 || din_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_handshake: out_valid=%b in_ready=%b required 0/1", dout_valid, din_ready);
    end
    asserts++;
    if (dout !== '0 || dout_max !== '0) begin
      failures++;
      $display("FAIL reset_outputs: idx=%0d max=%0d required 0/0", dout, dout_max);
    end
    asserts++;
    if (dout1_valid !== 1'b0 || din1_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_single: out_valid=%b in_ready=%b required 0/1", dout1_valid, din1_ready);
    end
    step();
    step();
    rst_n = 1'b1;
    step();
    $display("txn: reset released");
  endtask

  task automatic test_basic();
    send(1, 5, 3, 2);
    wait_result(4);
  endtask

  task automatic test_ties();
    send(4, 7, 7, 1);
    wait_result(4);
    send(0, 0, 0, 0);
    wait_result(4);
    send(6, 6, 6, 6);
    wait_result(4);
  endtask

  task automatic test_backpressure();
    int   n;
    exp_t e;
    dout_ready = 1'b0;
    send(2, 0, 3, 3);
    n = 0;
    while (!dout_valid && n < 40) begin
      step();
      n++;
    end
    e.idx = -1;
    e.mx  = -1;
    if (sb.size() != 0) e = sb.pop_front();
    for (int i = 0; i < 10; i++) begin
      asserts++;
      if (dout_valid !== 1'b1 || din_ready !== 1'b0 || dout !== IW'(e.idx) || dout_max !== CW'(e.mx)) begin
        failures++;
        $display("FAIL backpressure_hold: cycle %0d valid=%b in_ready=%b idx=%0d max=%0d required 1/0/%0d/%0d",
                 i, dout_valid, din_ready, dout, dout_max, e.idx, e.mx);
      end
      step();
    end
    $display("txn: backpressure held idx=%0d max=%0d (expected %0d/%0d)", dout, dout_max, e.idx, e.mx);
    dout_ready = 1'b1;
    step();
    asserts++;
    if (dout_valid !== 1'b0) begin
      failures++;
      $display("FAIL backpressure_release: out_valid=%b required 0", dout_valid);
    end
  endtask

  task automatic test_isolation();
    send(0, 1, 2, 3);
    set_din(7, 7, 7, 7);
    din_valid = 1'b1;
    wait_result(4);
    // Back in IDLE with the second vector still offered: this is its handshake cycle.
    asserts++;
    if (din_ready !== 1'b1) begin
      failures++;
      $display("FAIL isolation_ready: in_ready=%b required 1", din_ready);
    end
    sb.push_back(model(7, 7, 7, 7));
    step();
    din_valid = 1'b0;
    wait_result(4);
  endtask

  task automatic test_reset_mid_scan();
    int seen;
    send(5, 6, 7, 1);
    step();
    rst_n = 1'b0;
    #1;
    asserts++;
    if (dout_valid !== 1'b0 || din_ready !== 1'b1) begin
      failures++;
      $display("FAIL midscan_handshake: out_valid=%b in_ready=%b required 0/1", dout_valid, din_ready);
    end
    asserts++;
    if (dout !== '0 || dout_max !== '0) begin
      failures++;
      $display("FAIL midscan_outputs: idx=%0d max=%0d required 0/0", dout, dout_max);
    end
    if (sb.size() != 0) void'(sb.pop_back());
    step();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (dout_valid === 1'b1) seen++;
      step();
    end
    asserts++;
    if (seen != 0) begin
      failures++;
      $display("FAIL midscan_no_valid: valid cycles=%0d required 0", seen);
    end
    $display("txn: reset mid-scan discarded result");
    send(3, 1, 0, 2);
    wait_result(4);
  endtask

  task automatic test_single_group();
    exp_t e;
    int   lat;
    din1[0]    = CW'(5);
    din1_valid = 1'b1;
    asserts++;
    if (din1_ready !== 1'b1) begin
      failures++;
      $display("FAIL single_ready: in_ready=%b required 1", din1_ready);
    end
    e.idx = 0;
    e.mx  = 5;
    sb.push_back(e);
    step();
    din1_valid = 1'b0;
    lat = 1;
    while (!dout1_valid && lat < 10) begin
      step();
      lat++;
    end
    e = sb.pop_front();
    asserts++;
    if (lat != 1 || dout1_valid !== 1'b1) begin
      failures++;
      $display("FAIL single_latency: got %0d cycles valid=%b required 1", lat, dout1_valid);
    end
    asserts++;
    if (dout1 !== 1'(e.idx) || dout1_max !== CW'(e.mx)) begin
      failures++;
      $display("FAIL single_result: idx=%0d max=%0d required %0d/%0d", dout1, dout1_max, e.idx, e.mx);
    end
    $display("txn: single idx=%0d max=%0d latency=%0d", dout1, dout1_max, lat);
    step();
    asserts++;
    if (dout1_valid !== 1'b0 || din1_ready !== 1'b1) begin
      failures++;
      $display("FAIL single_consume: out_valid=%b in_ready=%b required 0/1", dout1_valid, din1_ready);
    end
  endtask

  task automatic test_back_to_back();
    int a, b, c, d;
    for (int k = 0; k < 8; k++) begin
      a = int'($urandom_range(0, 7));
      b = int'($urandom_range(0, 7));
      c = int'($urandom_range(0, 7));
      d = int'($urandom_range(0, 7));
      send(a, b, c, d);
      wait_result(4);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ties();
    test_backpressure();
    test_isolation();
    test_reset_mid_scan();
    test_single_group();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule
